hex_keypad_reader: RTL and testbench

//  Scans a 4x4 hex keypad and debounces it, then assembles key presses into a
//  16-bit value. Each accepted key shifts one nibble in from the right.
//  val/write_en connect directly to the val/write_en inputs of the 7-seg display

---
 rtl/hex_keypad_reader.sv | 196 +++++++++++++++++++
 tb/tb_hex_keypad_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_reader.sv
// Scans and debounces a 4x4 hex keypad, then shifts each accepted key into a
// 16-bit value (newest nibble in [3:0]) that drives the 7-segment display.
module hex_keypad_reader #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 20000
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [3:0]  col_n,
    input  logic        clr_val,
    output logic [3:0]  row_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] val,
    output logic        write_en
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [3:0]      col_meta;
    logic [3:0]      col_s;
    logic [SW-1:0]   scan_cnt;
    logic [DW-1:0]   deb_cnt;
    logic [1:0]      cand_row;
    logic [1:0]      cand_col;

    logic            slot_end;
    logic            single_zero;
    logic [1:0]      hit_col;
    logic [3:0]      cand_pat;
    logic            col_match;
    logic            col_idle;
    logic            deb_done;
    logic            capture;
    logic            accept;
    logic            advance_row;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: key_map = 4'h1;
            4'b00_01: key_map = 4'h2;
            4'b00_10: key_map = 4'h3;
            4'b00_11: key_map = 4'hA;
            4'b01_00: key_map = 4'h4;
            4'b01_01: key_map = 4'h5;
            4'b01_10: key_map = 4'h6;
            4'b01_11: key_map = 4'hB;
            4'b10_00: key_map = 4'h7;
            4'b10_01: key_map = 4'h8;
            4'b10_10: key_map = 4'h9;
            4'b10_11: key_map = 4'hC;
            4'b11_00: key_map = 4'h0;
            4'b11_01: key_map = 4'hF;
            4'b11_10: key_map = 4'hE;
            default:  key_map = 4'hD;
        endcase
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] rn);
        case (rn)
            4'b1101: row_index = 2'd1;
            4'b1011: row_index = 2'd2;
            4'b0111: row_index = 2'd3;
            default: row_index = 2'd0;
        endcase
    endfunction

    // NOTE: non-blocking assignments keep the two flops a true shift chain.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            col_meta <= 4'b1111;
            col_s    <= 4'b1111;
        end else begin
            col_meta <= col_n;
            col_s    <= col_meta;
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        single_zero = 1'b1;
        hit_col     = 2'd0;
        case (col_s)
            4'b1110: hit_col = 2'd0;
            4'b1101: hit_col = 2'd1;
            4'b1011: hit_col = 2'd2;
            4'b0111: hit_col = 2'd3;
            default: single_zero = 1'b0;
        endcase
    end

    assign slot_end  = (scan_cnt == SCAN_LAST);
    assign cand_pat  = ~(4'b0001 << cand_col);
    assign col_match = (col_s == cand_pat);
    assign col_idle  = (col_s == 4'b1111);
    assign deb_done  = (deb_cnt == DEB_LAST);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= S_SCAN;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_SCAN: begin
                if (slot_end && single_zero) next_state = S_DEBOUNCE;
            end
            S_DEBOUNCE: begin
                if (!col_match)    next_state = S_SCAN;
                else if (deb_done) next_state = S_HELD;
            end
            S_HELD: begin
                if (col_idle && deb_done) next_state = S_SCAN;
            end
            default: next_state = S_SCAN;
        endcase
    end

    always_comb begin
        capture     = 1'b0;
        accept      = 1'b0;
        advance_row = 1'b0;
        case (state)
            S_SCAN: begin
                capture     = slot_end && single_zero;
                advance_row = slot_end && !single_zero;
            end
            S_DEBOUNCE: begin
                accept      = col_match && deb_done;
                advance_row = !col_match;
            end
            S_HELD: begin
                advance_row = col_idle && deb_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            row_n    <= 4'b1110;
            scan_cnt <= '0;
            deb_cnt  <= '0;
            cand_row <= 2'd0;
            cand_col <= 2'd0;
        end else begin
            if (state == S_SCAN) scan_cnt <= slot_end ? '0 : scan_cnt + 1'b1;

            if (advance_row) row_n <= {row_n[2:0], row_n[3]};

            if (capture) begin
                cand_row <= row_index(row_n);
                cand_col <= hit_col;
            end

            // The same counter times the press in DEBOUNCE and the release in HELD.
            case (state)
                S_DEBOUNCE: deb_cnt <= (col_match && !deb_done) ? deb_cnt + 1'b1 : '0;
                S_HELD:     deb_cnt <= (col_idle  && !deb_done) ? deb_cnt + 1'b1 : '0;
                default:    deb_cnt <= '0;
            endcase
        end
    end

    // A clear request overrides the shift but never suppresses key reporting.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            val       <= 16'h0000;
            write_en  <= 1'b0;
        end else begin
            key_valid <= accept;
            write_en  <= accept || clr_val;
            if (accept) key_code <= key_map(cand_row, cand_col);
            if (clr_val)     val <= 16'h0000;
            else if (accept) val <= {val[11:0], key_map(cand_row, cand_col)};
        end
    end

    a_kv_has_we: assert property (@(posedge clk) disable iff (!clr_n) key_valid |-> write_en);
    a_row_onehot: assert property (@(posedge clk) disable iff (!clr_n) $onehot(~row_n));

endmodule

// File: tb/tb_hex_keypad_reader.sv
// Randomized bench for hex_keypad_reader: a behavioural keypad drives col_n from
// row_n, and a monitor predicts every key/val event from the keys pressed.
module tb_hex_keypad_reader;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 8;

    logic        clk;
    logic        clr_n;
    logic [3:0]  col_n;
    logic        clr_val;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] val;
    logic        write_en;

    hex_keypad_reader #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .col_n     (col_n),
        .clr_val   (clr_val),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .val       (val),
        .write_en  (write_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad legend indexed by row*4+col.
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'h0, 4'hF, 4'hE, 4'hD};

    logic [15:0] key_mask;
    logic        bounce_off;

    // A pressed key pulls its column low whenever its row is driven.
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mask[r*4+c] && !row_n[r] && !bounce_off) col_n[c] = 1'b0;
    end

    int          n_tests;
    int          n_fail;
    int          accept_cnt;
    int          exp_accepts;
    int          cyc;
    int          accept_cyc;
    logic        armed;
    logic [3:0]  exp_key;
    logic [15:0] model_val;
    logic [15:0] prev_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic monitor();
        logic exp_we;
        forever begin
            @(negedge clk);
            cyc++;
            if (!clr_n) begin
                model_val = 16'h0000;
                prev_val  = 16'h0000;
            end else begin
                exp_we = key_valid || clr_val;
                if (key_valid) begin
                    check("kv_expected", armed, 1);
                    check("key_code", key_code, exp_key);
                    accept_cnt++;
                    accept_cyc = cyc;
                end
                if (write_en || exp_we) begin
                    check("write_en", write_en, exp_we);
                    if (clr_val)        model_val = 16'h0000;
                    else if (key_valid) model_val = {model_val[11:0], exp_key};
                    check("val", val, model_val);
                end else if (val !== prev_val) begin
                    check("val_stable", val, prev_val);
                end
                prev_val = val;
            end
        end
    endtask

    task automatic wait_accept(input int start);
        int n = 0;
        while (accept_cnt == start && n < 400) begin
            step(1);
            n++;
        end
        check("accept_seen", accept_cnt != start, 1);
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        int idx = 0;
        int start;
        for (int i = 0; i < 16; i++) if (keymap[i] == k) idx = i;
        exp_key  = k;
        armed    = 1'b1;
        start    = accept_cnt;
        key_mask = 16'(1) << idx;
        wait_accept(start);
        exp_accepts++;
        armed = 1'b0;
        step(hold);
        key_mask = 16'h0000;
        step(DEBOUNCE + 6);
    endtask

    task automatic pulse_clr();
        clr_val = 1'b1;
        step(1);
        clr_val = 1'b0;
        step(2);
    endtask

    logic [15:0] t3_exp [5] = '{16'h0001, 16'h001A, 16'h01A0, 16'h1A0F, 16'hA0F7};
    logic [3:0]  t3_key [5] = '{4'h1, 4'hA, 4'h0, 4'hF, 4'h7};

    initial begin
        int run;
        int changes;
        int stable_cyc;
        int n;
        logic [3:0] last_row;
        logic [3:0] k;

        n_tests = 0; n_fail = 0; accept_cnt = 0; exp_accepts = 0; cyc = 0; accept_cyc = 0;
        armed = 1'b0; exp_key = 4'h0; model_val = 16'h0; prev_val = 16'h0;
        key_mask = 16'h0; bounce_off = 1'b0; clr_val = 1'b0; clr_n = 1'b0;
        fork monitor(); join_none

        // T1: reset values, async reset mid-scan, reset aborting a debounce
        step(3);
        check("rst_row_n", row_n, 4'b1110);
        check("rst_val", val, 16'h0000);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_valid", key_valid, 0);
        check("rst_write_en", write_en, 0);
        clr_n = 1'b1;
        step(9);
        clr_n = 1'b0;
        #1;
        check("async_rst_row_n", row_n, 4'b1110);
        step(2);
        clr_n = 1'b1;
        step(1);

        key_mask = 16'(1) << 1;
        run = 0; n = 0;
        while (run < SCAN_DIV + 1 && n < 200) begin
            step(1);
            n++;
            run = (row_n == 4'b1110) ? run + 1 : 0;
        end
        check("deb_frozen_seen", run >= SCAN_DIV + 1, 1);
        clr_n = 1'b0;
        step(2);
        key_mask = 16'h0;
        step(2);
        clr_n = 1'b1;
        step(40);
        check("abort_no_accept", accept_cnt, 0);
        check("abort_val", val, 16'h0000);

        // T2: single held key
        press(4'h5, 45);
        check("t2_val", val, 16'h0005);
        check("t2_accepts", accept_cnt, exp_accepts);

        // T3: sequence with wrap, starting from a cleared value
        pulse_clr();
        check("t3_cleared", val, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            press(t3_key[i], 5);
            check("t3_val", val, t3_exp[i]);
        end
        check("t3_accepts", accept_cnt, exp_accepts);

        // T4: bouncing press and release on '9'
        exp_key = 4'h9; armed = 1'b1; n = accept_cnt;
        key_mask = 16'(1) << 10;
        bounce_off = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step(3);
            bounce_off = ~bounce_off;
        end
        step(3);
        bounce_off = 1'b0;
        stable_cyc = cyc;
        check("t4_no_early", accept_cnt, n);
        wait_accept(n);
        exp_accepts++;
        armed = 1'b0;
        check("t4_latency_ok", (accept_cyc - stable_cyc) >= DEBOUNCE + 2, 1);
        step(5);
        for (int i = 0; i < 13; i++) begin
            bounce_off = ~bounce_off;
            step(3);
        end
        key_mask = 16'h0; bounce_off = 1'b0;
        step(40);
        check("t4_single_accept", accept_cnt, exp_accepts);
        check("t4_val", val, 16'h0F79);

        // T5: two columns low in one row are ignored and scanning continues
        key_mask = 16'h0030;
        last_row = row_n; changes = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (row_n != last_row) changes++;
            last_row = row_n;
        end
        key_mask = 16'h0;
        check("t5_scanning", changes >= 8, 1);
        check("t5_no_accept", accept_cnt, exp_accepts);
        step(10);

        // T6: clear held across the accept of 'E'
        clr_val = 1'b1;
        press(4'hE, 3);
        clr_val = 1'b0;
        step(2);
        check("t6_val", val, 16'h0000);
        check("t6_key_code", key_code, 4'hE);
        press(4'hC, 2);
        check("t6_after", val, 16'h000C);

        // T7: random keys, holds, gaps and clears
        for (int i = 0; i < 10; i++) begin
            k = 4'($urandom_range(0, 15));
            step($urandom_range(0, 10));
            press(k, $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) pulse_clr();
        end
        check("t7_val", val, model_val);
        check("t7_accepts", accept_cnt, exp_accepts);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
